// File: rtl/stg_pkg.sv
// Shared state encodings for the shoot-'em-up game controller.
package stg_pkg;

    typedef enum logic [3:0] {
        ST_INIT     = 4'b0000,
        ST_START    = 4'b0001,
        ST_PLAY     = 4'b0010,
        ST_PAUSE    = 4'b0011,
        ST_BOMB     = 4'b0110,
        ST_HIT      = 4'b1010,
        ST_SUCCESS  = 4'b1000,
        ST_GAMEOVER = 4'b1001
    } state_t;

    function automatic logic is_shielded(state_t s);
        return (s == ST_HIT) || (s == ST_BOMB);
    endfunction

endpackage

// File: rtl/stg_edge_det.sv
// Rising-edge detector for a raw level button; held levels fire once.
module stg_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/stg_game_ctrl.sv
// Game flow controller: lives, bombs, timed hit/bomb shields.
// Optional pause feature enabled by defining STG_PAUSE_EN.
module stg_game_ctrl
    import stg_pkg::*;
#(
    parameter int LIFE_W    = 4,
    parameter int LIFE_INIT = 3,
    parameter int BOMB_INIT = 3,
    parameter int T_W       = 32,
    parameter int T_INIT    = 20000000,
    parameter int T_HIT     = 20000000,
    parameter int T_BOMB    = 40000000
) (
    input  logic              clk,
    input  logic              hard_reset,
    input  logic              enter,
    input  logic              bomb,
    input  logic              pause,
    input  logic              collision,
    input  logic              die,
    output logic [LIFE_W-1:0] num_life,
    output logic [LIFE_W-1:0] num_bomb,
    output logic [3:0]        game_state,
    output logic              game_en,
    output logic              game_reset,
    output logic              invincible
);

    localparam logic [LIFE_W-1:0] L_INIT = LIFE_W'(LIFE_INIT);
    localparam logic [LIFE_W-1:0] B_INIT = LIFE_W'(BOMB_INIT);

    if (LIFE_INIT >= (1 << LIFE_W) || BOMB_INIT >= (1 << LIFE_W)) begin : g_bad_init
        $error("LIFE_INIT/BOMB_INIT do not fit in LIFE_W bits");
    end

    logic enter_r;
    logic bomb_r;
    logic pause_r;

    stg_edge_det u_enter (.clk(clk), .rst(hard_reset), .level(enter), .rise(enter_r));
    stg_edge_det u_bomb  (.clk(clk), .rst(hard_reset), .level(bomb),  .rise(bomb_r));

`ifdef STG_PAUSE_EN
    stg_edge_det u_pause (.clk(clk), .rst(hard_reset), .level(pause), .rise(pause_r));
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_r      = 1'b0;
`endif

    state_t            state, state_n;
    logic [T_W-1:0]    timer, timer_n;
    logic [LIFE_W-1:0] life_n, bombs_n;
    logic              en_n, grst_n;

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state      <= ST_INIT;
            timer      <= T_W'(T_INIT);
            num_life   <= L_INIT;
            num_bomb   <= B_INIT;
            game_en    <= 1'b0;
            game_reset <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            num_life   <= life_n;
            num_bomb   <= bombs_n;
            game_en    <= en_n;
            game_reset <= grst_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        life_n  = num_life;
        bombs_n = num_bomb;
        en_n    = game_en;
        grst_n  = 1'b0;
        unique case (state)
            ST_INIT: begin
                if (timer == '0) state_n = ST_START;
                else             timer_n = timer - 1'b1;
            end
            ST_START: begin
                if (enter_r) begin
                    grst_n  = 1'b1;
                    en_n    = 1'b1;
                    state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (die) begin
                    en_n    = 1'b0;
                    state_n = ST_SUCCESS;
                end else if (collision) begin
                    if (num_life == '0) begin
                        en_n    = 1'b0;
                        state_n = ST_GAMEOVER;
                    end else begin
                        life_n  = num_life - 1'b1;
                        timer_n = T_W'(T_HIT);
                        state_n = ST_HIT;
                    end
                end else if (bomb_r && num_bomb != '0) begin
                    bombs_n = num_bomb - 1'b1;
                    timer_n = T_W'(T_BOMB);
                    state_n = ST_BOMB;
                end else if (pause_r) begin
                    en_n    = 1'b0;
                    state_n = ST_PAUSE;
                end
            end
            // Shielded: collision ignored; a bomb may extend a hit shield.
            ST_HIT, ST_BOMB: begin
                if (die) begin
                    en_n    = 1'b0;
                    state_n = ST_SUCCESS;
                end else if (state == ST_HIT && bomb_r && num_bomb != '0) begin
                    bombs_n = num_bomb - 1'b1;
                    timer_n = T_W'(T_BOMB);
                    state_n = ST_BOMB;
                end else if (timer == '0) begin
                    state_n = ST_PLAY;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
`ifdef STG_PAUSE_EN
            ST_PAUSE: begin
                if (pause_r) begin
                    en_n    = 1'b1;
                    state_n = ST_PLAY;
                end
            end
`endif
            ST_SUCCESS, ST_GAMEOVER: begin
                if (enter_r) begin
                    life_n  = L_INIT;
                    bombs_n = B_INIT;
                    timer_n = '0;
                    grst_n  = 1'b1;
                    en_n    = 1'b0;
                    state_n = ST_START;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    assign game_state = state;
    assign invincible = is_shielded(state);

endmodule

// File: tb/tb_stg_game_ctrl.sv
// Directed table-plus-sequence bench for stg_game_ctrl.
module tb_stg_game_ctrl;

    logic       clk = 1'b0;
    logic       hard_reset;
    logic       enter, bomb, pause, collision, die;
    logic [3:0] num_life, num_bomb, game_state;
    logic       game_en, game_reset, invincible;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       i_ent, i_bmb, i_pse, i_col, i_die;
        logic [3:0] e_st, e_life, e_bmb;
        logic       e_en, e_gr, e_inv;
    } vec_t;

    vec_t tbl[13];

    stg_game_ctrl #(
        .LIFE_W(4), .LIFE_INIT(3), .BOMB_INIT(3), .T_W(32),
        .T_INIT(4), .T_HIT(3), .T_BOMB(5)
    ) dut (
        .clk(clk), .hard_reset(hard_reset),
        .enter(enter), .bomb(bomb), .pause(pause),
        .collision(collision), .die(die),
        .num_life(num_life), .num_bomb(num_bomb),
        .game_state(game_state), .game_en(game_en),
        .game_reset(game_reset), .invincible(invincible)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void cmp(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    task automatic step(input logic e, b, p, c, d);
        enter = e; bomb = b; pause = p; collision = c; die = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int st, lf, bm, en, gr, inv);
        cmp({nm, ".state"}, int'(game_state), st);
        cmp({nm, ".life"},  int'(num_life),   lf);
        cmp({nm, ".bomb"},  int'(num_bomb),   bm);
        cmp({nm, ".en"},    int'(game_en),    en);
        cmp({nm, ".greset"}, int'(game_reset), gr);
        cmp({nm, ".inv"},   int'(invincible), inv);
    endtask

    task automatic wait_play(input string nm, input int max);
        for (int i = 0; i < max && game_state != 4'h2; i++)
            step(0, 0, 0, 0, 0);
        cmp({nm, ".back_to_play"}, int'(game_state), 2);
    endtask

    initial begin
        tbl[0]  = '{0,0,0,0,0, 4'h0, 3, 3, 0, 0, 0};
        tbl[1]  = '{0,0,0,0,0, 4'h0, 3, 3, 0, 0, 0};
        tbl[2]  = '{0,0,0,0,0, 4'h0, 3, 3, 0, 0, 0};
        tbl[3]  = '{0,0,0,0,0, 4'h0, 3, 3, 0, 0, 0};
        tbl[4]  = '{0,0,0,0,0, 4'h1, 3, 3, 0, 0, 0};
        tbl[5]  = '{1,0,0,0,0, 4'h2, 3, 3, 1, 1, 0};
        tbl[6]  = '{1,0,0,0,0, 4'h2, 3, 3, 1, 0, 0};
        tbl[7]  = '{0,0,0,0,0, 4'h2, 3, 3, 1, 0, 0};
        tbl[8]  = '{0,0,0,1,0, 4'hA, 2, 3, 1, 0, 1};
        tbl[9]  = '{0,0,0,0,0, 4'hA, 2, 3, 1, 0, 1};
        tbl[10] = '{0,0,0,1,0, 4'hA, 2, 3, 1, 0, 1};
        tbl[11] = '{0,0,0,0,0, 4'hA, 2, 3, 1, 0, 1};
        tbl[12] = '{0,0,0,0,0, 4'h2, 2, 3, 1, 0, 0};

        hard_reset = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset", 0, 3, 3, 0, 0, 0);
        hard_reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].i_ent, tbl[i].i_bmb, tbl[i].i_pse,
                 tbl[i].i_col, tbl[i].i_die);
            chk($sformatf("vec%0d", i), int'(tbl[i].e_st),
                int'(tbl[i].e_life), int'(tbl[i].e_bmb),
                int'(tbl[i].e_en), int'(tbl[i].e_gr), int'(tbl[i].e_inv));
        end

        // Bomb held for 20 cycles: exactly one bomb spent
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 0);
            if (i == 0) chk("bomb_edge", 6, 2, 2, 1, 0, 1);
        end
        chk("bomb_held", 2, 2, 2, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Bomb during a hit shield
        step(0, 0, 0, 1, 0);
        chk("hit2", 10, 1, 2, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        chk("bomb_in_hit", 6, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        wait_play("bomb_in_hit", 10);

        // die beats collision, then restart
        step(0, 0, 0, 1, 1);
        chk("die_col", 8, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("succ_col", 8, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("succ_enter", 1, 3, 3, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("start_idle", 1, 3, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("replay", 2, 3, 3, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Lose all lives, then game over and restart
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0);
            chk($sformatf("lose%0d", k), 10, 2 - k, 3, 1, 0, 1);
            step(0, 0, 0, 0, 0);
            wait_play($sformatf("lose%0d", k), 8);
        end
        step(0, 0, 0, 1, 0);
        chk("gameover", 9, 0, 3, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("gameover_col", 9, 0, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("go_enter", 1, 3, 3, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Exhaust bombs; a fourth bomb edge is ignored
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 0);
            chk($sformatf("usebomb%0d", k), 6, 3, 2 - k, 1, 0, 1);
            step(0, 0, 0, 0, 0);
            wait_play($sformatf("usebomb%0d", k), 10);
        end
        step(0, 1, 0, 0, 0);
        chk("no_bomb", 2, 3, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // hard_reset mid-HIT abandons the shield
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        hard_reset = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("rst_mid_hit", 0, 3, 3, 0, 0, 0);
        hard_reset = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        cmp("restart.state", int'(game_state), 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

`ifdef STG_PAUSE_EN
        step(0, 0, 1, 0, 0);
        chk("pause", 3, 3, 3, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("pause_col", 3, 3, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("unpause", 2, 3, 3, 1, 0, 0);
`else
        step(0, 0, 1, 0, 0);
        chk("pause_off", 2, 3, 3, 1, 0, 0);
`endif
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
